// File: rtl/multicycle_adder_ctrl.sv
// Multicycle N-bit add/subtract controller: one W-bit carry-lookahead slice is
// reused LSB-first over N/W cycles, with a start/ready/done handshake.

module partial_full_adder1b (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;
endmodule

module cla_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;

  for (genvar i = 0; i < W; i++) begin : g_bit
    partial_full_adder1b u_pfa (
      .a (a[i]),
      .b (b[i]),
      .c (c[i]),
      .s (sum[i]),
      .p (p[i]),
      .g (g[i])
    );
  end

  // Each carry is the group generate/propagate of bits [i:0] applied to cin,
  // so no carry depends on a lower carry signal.
  always_comb begin
    logic gacc;
    logic pacc;
    c    = '0;
    gacc = 1'b0;
    pacc = 1'b1;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      gacc     = g[i] | (p[i] & gacc);
      pacc     = pacc & p[i];
      c[i + 1] = gacc | (pacc & cin);
    end
  end

  assign cout = c[W];
  assign cmsb = c[W-1];
endmodule

module multicycle_adder_ctrl #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_i,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         c_o,
  output logic         ovf
);
  if (W < 1 || W > N || (N % W) != 0) begin : g_param_check
    $error("multicycle_adder_ctrl: N must be a multiple of W with 1 <= W <= N");
  end

  localparam int NS = N / W;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           last;
  logic [W-1:0]   sl_a;
  logic [W-1:0]   sl_b;
  logic [W-1:0]   sl_sum;
  logic           sl_cout;
  logic           sl_cmsb;

  assign last = (cnt == CW'(NS - 1));
  assign sl_a = op_a[int'(cnt) * W +: W];
  assign sl_b = op_b[int'(cnt) * W +: W];

  cla_slice #(.W(W)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout),
    .cmsb (sl_cmsb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtract is folded into acceptance: B is inverted and carry-in forced to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c_o   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b ^ {N{sub}};
            carry <= sub | c_i;
            cnt   <= '0;
          end
        end
        RUN: begin
          s[int'(cnt) * W +: W] <= sl_sum;
          carry                 <= sl_cout;
          cnt                   <= cnt + CW'(1);
          if (last) begin
            c_o <= sl_cout;
            ovf <= sl_cmsb ^ sl_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Self-checking bench: four slice widths (16, 1, 8, 64) run side by side on
// shared stimulus and are compared against a plain-arithmetic reference.
module tb_multicycle_adder_ctrl;
  localparam int WV[4] = '{16, 1, 8, 64};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic        c_i = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;

  logic        ready_v[4];
  logic        busy_v[4];
  logic        done_v[4];
  logic [63:0] s_v[4];
  logic        co_v[4];
  logic        ovf_v[4];

  int          checks = 0;
  int          errors = 0;
  int          lat[4];
  int          ndone[4];
  logic [63:0] cap_s[4];
  logic        cap_co[4];
  logic        cap_ovf[4];

  always #5 clk = ~clk;

  multicycle_adder_ctrl #(.N(64), .W(16)) u_w16 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_i(c_i),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .c_o(co_v[0]), .ovf(ovf_v[0])
  );
  multicycle_adder_ctrl #(.N(64), .W(1)) u_w1 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_i(c_i),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .c_o(co_v[1]), .ovf(ovf_v[1])
  );
  multicycle_adder_ctrl #(.N(64), .W(8)) u_w8 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_i(c_i),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .c_o(co_v[2]), .ovf(ovf_v[2])
  );
  multicycle_adder_ctrl #(.N(64), .W(64)) u_w64 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b), .c_i(c_i),
    .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]), .s(s_v[3]), .c_o(co_v[3]), .ovf(ovf_v[3])
  );

  function automatic void model(input logic [63:0] ma, input logic [63:0] mb, input logic msub,
                                input logic mci, output logic [63:0] ms, output logic mco,
                                output logic mov);
    logic [64:0] r;
    if (msub) begin
      ms  = ma - mb;
      mco = (ma >= mb);
      mov = (ma[63] != mb[63]) && (ms[63] != ma[63]);
    end else begin
      r   = {1'b0, ma} + {1'b0, mb} + {64'd0, mci};
      ms  = r[63:0];
      mco = r[64];
      mov = (ma[63] == mb[63]) && (ms[63] != ma[63]);
    end
  endfunction

  // Issues one operation to all instances and records latency, done count and
  // the result captured in each instance's done cycle.
  task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tsub,
                        input logic tci);
    int  w;
    bit  all_seen;
    bit  any_done;
    w = 0;
    @(negedge clk);
    while (!(ready_v[0] && ready_v[1] && ready_v[2] && ready_v[3]) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL ready_wait instances never all ready within %0d cycles", w);
    end
    a = ta; b = tb_v; sub = tsub; c_i = tci; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0; ndone[i] = 0; cap_s[i] = 'x; cap_co[i] = 1'bx; cap_ovf[i] = 1'bx;
    end
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = {$urandom, $urandom}; sub = ~tsub; c_i = ~tci;
    for (int e = 1; e <= 70; e++) begin
      @(negedge clk);
      all_seen = 1'b1;
      any_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (done_v[i]) begin
          ndone[i]++;
          any_done = 1'b1;
          if (lat[i] == 0) begin
            lat[i] = e; cap_s[i] = s_v[i]; cap_co[i] = co_v[i]; cap_ovf[i] = ovf_v[i];
          end
        end
        if (lat[i] == 0) all_seen = 1'b0;
      end
      if (all_seen && !any_done) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready_v[0], busy_v[0], done_v[0], co_v[0], ovf_v[0]} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=10000",
               {ready_v[0], busy_v[0], done_v[0], co_v[0], ovf_v[0]});
    end
    checks++;
    if (s_v[0] !== 64'd0) begin
      errors++; $display("FAIL reset_s got=%h exp=0", s_v[0]);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_v[0] !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got=%b exp=1", ready_v[0]);
    end
  endtask

  task automatic test_carry_chain();
    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    checks++;
    if ({cap_s[0], cap_co[0], cap_ovf[0]} !== {64'h0000_0001_0000_0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL carry_chain got s=%h c_o=%b ovf=%b exp s=0000000100000000 c_o=0 ovf=0",
               cap_s[0], cap_co[0], cap_ovf[0]);
    end
    checks++;
    if (lat[0] !== 4 || ndone[0] !== 1) begin
      errors++; $display("FAIL carry_chain_latency got lat=%0d dones=%0d exp lat=4 dones=1", lat[0], ndone[0]);
    end
  endtask

  task automatic test_full_ripple();
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1);
    checks++;
    if ({cap_s[0], cap_co[0], cap_ovf[0]} !== {64'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL full_ripple got s=%h c_o=%b ovf=%b exp s=0 c_o=1 ovf=0",
               cap_s[0], cap_co[0], cap_ovf[0]);
    end
  endtask

  task automatic test_subtract();
    run_op(64'd5, 64'd7, 1'b1, 1'b1);
    checks++;
    if ({cap_s[0], cap_co[0], cap_ovf[0]} !== {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL subtract got s=%h c_o=%b ovf=%b exp s=fffffffffffffffe c_o=0 ovf=0",
               cap_s[0], cap_co[0], cap_ovf[0]);
    end
  endtask

  task automatic test_overflow();
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    checks++;
    if ({cap_s[0], cap_co[0], cap_ovf[0]} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ovf_add got s=%h c_o=%b ovf=%b exp s=8000000000000000 c_o=0 ovf=1",
               cap_s[0], cap_co[0], cap_ovf[0]);
    end
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0);
    checks++;
    if ({cap_s[0], cap_co[0], cap_ovf[0]} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_sub got s=%h c_o=%b ovf=%b exp s=7fffffffffffffff c_o=1 ovf=1",
               cap_s[0], cap_co[0], cap_ovf[0]);
    end
  endtask

  task automatic test_ignore_start();
    logic [63:0] es;
    logic        eco, eov;
    logic [63:0] got_s;
    int          nd;
    model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b1, es, eco, eov);
    run_op(64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_2222_3333_4444; sub = 1'b0; c_i = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 64'hDEAD_BEEF_0000_0001; b = 64'h5555_AAAA_5555_AAAA; sub = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_v[0] !== 1'b1 || ready_v[0] !== 1'b0) begin
      errors++; $display("FAIL ignore_busy got busy=%b ready=%b exp busy=1 ready=0", busy_v[0], ready_v[0]);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    got_s = 'x;
    for (int e = 0; e < 12; e++) begin
      if (done_v[0]) begin
        nd++;
        got_s = s_v[0];
      end
      @(negedge clk);
    end
    checks++;
    if (nd !== 1) begin
      errors++; $display("FAIL ignore_done_count got=%0d exp=1", nd);
    end
    checks++;
    if (got_s !== es || s_v[0] !== es) begin
      errors++; $display("FAIL ignore_result got=%h final=%h exp=%h", got_s, s_v[0], es);
    end
  endtask

  task automatic test_abort();
    logic [63:0] es;
    logic        eco, eov;
    int          nd;
    run_op(64'd0, 64'd0, 1'b0, 1'b0);
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0F0F_0F0F_0F0F_0F0F; sub = 1'b0; c_i = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({ready_v[0], busy_v[0], done_v[0]} !== 3'b100 || s_v[0] !== 64'd0) begin
      errors++;
      $display("FAIL abort_async got ready=%b busy=%b done=%b s=%h exp ready=1 busy=0 done=0 s=0",
               ready_v[0], busy_v[0], done_v[0], s_v[0]);
    end
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    checks++;
    if (nd !== 0 || ready_v[0] !== 1'b1) begin
      errors++; $display("FAIL abort_no_done got dones=%0d ready=%b exp dones=0 ready=1", nd, ready_v[0]);
    end
    model(64'hCAFE_F00D_1234_5678, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0, es, eco, eov);
    run_op(64'hCAFE_F00D_1234_5678, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0);
    checks++;
    if ({cap_s[0], cap_co[0], cap_ovf[0]} !== {es, eco, eov} || lat[0] !== 4) begin
      errors++;
      $display("FAIL abort_restart got s=%h c_o=%b ovf=%b lat=%0d exp s=%h c_o=%b ovf=%b lat=4",
               cap_s[0], cap_co[0], cap_ovf[0], lat[0], es, eco, eov);
    end
  endtask

  task automatic test_random_sweep();
    logic [63:0] ta, tbv, es;
    logic        tsub, tci, eco, eov;
    for (int n = 0; n < 1000; n++) begin
      ta   = {$urandom, $urandom};
      tbv  = {$urandom, $urandom};
      tsub = 1'($urandom_range(1));
      tci  = 1'($urandom_range(1));
      if (n % 40 == 0) ta = ~64'd0;
      if (n % 40 == 1) tbv = ~64'd0;
      if (n % 40 == 2) begin ta = 64'h7FFF_FFFF_FFFF_FFFF; tbv = {32'd0, $urandom}; end
      model(ta, tbv, tsub, tci, es, eco, eov);
      run_op(ta, tbv, tsub, tci);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({cap_s[i], cap_co[i], cap_ovf[i]} !== {es, eco, eov}) begin
          errors++;
          $display("FAIL rand_result W=%0d a=%h b=%h sub=%b ci=%b got s=%h c_o=%b ovf=%b exp s=%h c_o=%b ovf=%b",
                   WV[i], ta, tbv, tsub, tci, cap_s[i], cap_co[i], cap_ovf[i], es, eco, eov);
        end
        checks++;
        if (lat[i] !== 64 / WV[i] || ndone[i] !== 1) begin
          errors++;
          $display("FAIL rand_latency W=%0d got lat=%0d dones=%0d exp lat=%0d dones=1",
                   WV[i], lat[i], ndone[i], 64 / WV[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_full_ripple();
    test_subtract();
    test_overflow();
    test_ignore_start();
    test_abort();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
